// File: rtl/r_forward_demixer_pkg.sv
// Shared AR-channel packing layout and skid-buffer state encoding.
// Both the forward mixer and the demixer use this package, so the layout cannot drift between them.
package r_forward_demixer_pkg;

  localparam int unsigned AR_ID_W     = 8;
  localparam int unsigned AR_ADDR_W   = 36;
  localparam int unsigned AR_LEN_W    = 8;
  localparam int unsigned AR_SIZE_W   = 3;
  localparam int unsigned AR_BURST_W  = 2;
  localparam int unsigned AR_LOCK_W   = 1;
  localparam int unsigned AR_CACHE_W  = 4;
  localparam int unsigned AR_PROT_W   = 3;
  localparam int unsigned AR_QOS_W    = 4;
  localparam int unsigned AR_REGION_W = 4;
  localparam int unsigned AR_USER_W   = 4;
  localparam int unsigned AR_PACK_W   = 77;

  localparam int unsigned AR_USER_OFF   = 0;
  localparam int unsigned AR_REGION_OFF = 4;
  localparam int unsigned AR_QOS_OFF    = 8;
  localparam int unsigned AR_PROT_OFF   = 12;
  localparam int unsigned AR_CACHE_OFF  = 15;
  localparam int unsigned AR_LOCK_OFF   = 19;
  localparam int unsigned AR_BURST_OFF  = 20;
  localparam int unsigned AR_SIZE_OFF   = 22;
  localparam int unsigned AR_LEN_OFF    = 25;
  localparam int unsigned AR_ADDR_OFF   = 33;
  localparam int unsigned AR_ID_OFF     = 69;

  localparam logic [1:0] BURST_RESERVED = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/r_forward_demixer_skid.sv
// Generic 2-entry register slice (axi_skid_buffer): both valid and ready are
// driven from flops, so the input and output sides are timing-isolated.
module axi_skid_buffer
  import r_forward_demixer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] oreg_q, oreg_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             in_xfer, out_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      oreg_q  <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      oreg_q  <= oreg_d;
      sreg_q  <= sreg_d;
    end
  end

  // ready_q gates acceptance, so READY stays low on the first cycle after reset release
  // even though the state is already EMPTY.
  always_comb begin
    in_xfer  = in_valid && ready_q;
    out_xfer = (state_q != ST_EMPTY) && out_ready;
    state_d  = state_q;
    oreg_d   = oreg_q;
    sreg_d   = sreg_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          oreg_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          oreg_d = in_data;
        end else if (in_xfer) begin
          sreg_d  = in_data;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          oreg_d  = sreg_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    in_ready  = ready_q;
    out_valid = (state_q != ST_EMPTY);
    out_data  = oreg_q;
  end

endmodule

// File: rtl/r_forward_demixer.sv
// Unpacks the 77-bit packed read-address word into an AXI4 AR master channel
// through a registered skid buffer, and flags reserved burst encodings.
module r_forward_demixer
  import r_forward_demixer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [76:0] DATA,
  input  logic        VALID,
  output logic        READY,
  output logic [7:0]  ARID,
  output logic [35:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARLOCK,
  output logic [3:0]  ARCACHE,
  output logic [2:0]  ARPROT,
  output logic [3:0]  ARQOS,
  output logic [3:0]  ARREGION,
  output logic [3:0]  ARUSER,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic        BURST_ERR
);

  logic [AR_PACK_W-1:0] oreg;
  logic                 ready;
  logic                 burst_err_q, burst_err_d;

  axi_skid_buffer #(.WIDTH(AR_PACK_W)) u_skid (
    .clk      (CLK),
    .rst      (RESET),
    .in_data  (DATA),
    .in_valid (VALID),
    .in_ready (ready),
    .out_data (oreg),
    .out_valid(ARVALID),
    .out_ready(ARREADY)
  );

  // The word is forwarded unchanged; this only reports the reserved encoding.
  always_comb begin
    burst_err_d = VALID && ready &&
                  (DATA[AR_BURST_OFF +: AR_BURST_W] == BURST_RESERVED);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) burst_err_q <= 1'b0;
    else       burst_err_q <= burst_err_d;
  end

  always_comb begin
    READY     = ready;
    BURST_ERR = burst_err_q;
    ARID      = oreg[AR_ID_OFF     +: AR_ID_W];
    ARADDR    = oreg[AR_ADDR_OFF   +: AR_ADDR_W];
    ARLEN     = oreg[AR_LEN_OFF    +: AR_LEN_W];
    ARSIZE    = oreg[AR_SIZE_OFF   +: AR_SIZE_W];
    ARBURST   = oreg[AR_BURST_OFF  +: AR_BURST_W];
    ARLOCK    = oreg[AR_LOCK_OFF];
    ARCACHE   = oreg[AR_CACHE_OFF  +: AR_CACHE_W];
    ARPROT    = oreg[AR_PROT_OFF   +: AR_PROT_W];
    ARQOS     = oreg[AR_QOS_OFF    +: AR_QOS_W];
    ARREGION  = oreg[AR_REGION_OFF +: AR_REGION_W];
    ARUSER    = oreg[AR_USER_OFF   +: AR_USER_W];
  end

endmodule

// File: tb/tb_r_forward_demixer.sv
// Directed bench for r_forward_demixer: a vector table for ordering/backpressure
// plus hand-written reset, single-word, throughput and mid-operation reset sequences.
module tb_r_forward_demixer;

  logic        CLK, RESET, VALID, ARREADY;
  logic [76:0] DATA;
  logic        READY, ARVALID, BURST_ERR, ARLOCK;
  logic [7:0]  ARID, ARLEN;
  logic [35:0] ARADDR;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE, ARQOS, ARREGION, ARUSER;

  int checks   = 0;
  int failures = 0;

  r_forward_demixer dut (
    .CLK(CLK), .RESET(RESET), .DATA(DATA), .VALID(VALID), .READY(READY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARQOS(ARQOS), .ARREGION(ARREGION), .ARUSER(ARUSER), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .BURST_ERR(BURST_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       valid;
    logic [7:0] id;
    logic [1:0] burst;
    logic       arready;
    logic       exp_ready;
    logic       exp_arvalid;
    logic [7:0] exp_id;
    logic [1:0] exp_burst;
    logic       exp_berr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [76:0] mk(input logic [7:0] id, input logic [1:0] b);
    return {id, {28'h0, id}, 8'h00, 3'd2, b, 1'b0, 4'h0, 3'd0, 4'h0, 4'h0, id[3:0]};
  endfunction

  initial begin
    // id, burst, arready -> READY, ARVALID, ARID, ARBURST, BURST_ERR after the edge
    vecs[0]  = '{1'b1, 8'd1, 2'b01, 1'b0, 1'b1, 1'b1, 8'd1, 2'b01, 1'b0};
    vecs[1]  = '{1'b1, 8'd2, 2'b01, 1'b0, 1'b0, 1'b1, 8'd1, 2'b01, 1'b0};
    vecs[2]  = '{1'b1, 8'd3, 2'b01, 1'b0, 1'b0, 1'b1, 8'd1, 2'b01, 1'b0};
    vecs[3]  = '{1'b1, 8'd3, 2'b01, 1'b1, 1'b1, 1'b1, 8'd2, 2'b01, 1'b0};
    vecs[4]  = '{1'b1, 8'd3, 2'b01, 1'b0, 1'b0, 1'b1, 8'd2, 2'b01, 1'b0};
    vecs[5]  = '{1'b1, 8'd4, 2'b01, 1'b1, 1'b1, 1'b1, 8'd3, 2'b01, 1'b0};
    vecs[6]  = '{1'b1, 8'd4, 2'b01, 1'b1, 1'b1, 1'b1, 8'd4, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 8'd0, 2'b01, 1'b0};
    vecs[8]  = '{1'b1, 8'd5, 2'b11, 1'b0, 1'b1, 1'b1, 8'd5, 2'b11, 1'b1};
    vecs[9]  = '{1'b0, 8'd0, 2'b01, 1'b0, 1'b1, 1'b1, 8'd5, 2'b11, 1'b0};
    vecs[10] = '{1'b0, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 8'd0, 2'b01, 1'b0};

    RESET = 1'b1; VALID = 1'b0; ARREADY = 1'b0; DATA = '0;
    #2;
    check("rst_ready", READY, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_arid", ARID, 0);
    check("rst_berr", BURST_ERR, 0);
    step();
    step();
    check("rst_ready_clk", READY, 0);
    check("rst_arvalid_clk", ARVALID, 0);
    RESET = 1'b0;
    check("rel_ready_before_edge", READY, 0);
    step();
    check("rel_ready_after_edge", READY, 1);
    check("rel_arvalid", ARVALID, 0);

    for (int i = 0; i < 11; i++) begin
      VALID   = vecs[i].valid;
      DATA    = mk(vecs[i].id, vecs[i].burst);
      ARREADY = vecs[i].arready;
      step();
      check($sformatf("vec%0d_ready", i), READY, vecs[i].exp_ready);
      check($sformatf("vec%0d_arvalid", i), ARVALID, vecs[i].exp_arvalid);
      check($sformatf("vec%0d_berr", i), BURST_ERR, vecs[i].exp_berr);
      if (vecs[i].exp_arvalid) begin
        check($sformatf("vec%0d_arid", i), ARID, vecs[i].exp_id);
        check($sformatf("vec%0d_arburst", i), ARBURST, vecs[i].exp_burst);
      end
    end

    VALID = 1'b1; ARREADY = 1'b1;
    DATA  = {8'hA5, 36'h9_1234_5678, 8'h0F, 3'd3, 2'b01, 1'b0, 4'h3, 3'd2, 4'h7, 4'h1, 4'hC};
    step();
    VALID = 1'b0;
    check("single_arvalid", ARVALID, 1);
    check("single_arid", ARID, 8'hA5);
    check("single_araddr", ARADDR, 36'h912345678);
    check("single_arlen", ARLEN, 8'h0F);
    check("single_arsize", ARSIZE, 3);
    check("single_arburst", ARBURST, 2'b01);
    check("single_arlock", ARLOCK, 0);
    check("single_arcache", ARCACHE, 4'h3);
    check("single_arprot", ARPROT, 2);
    check("single_arqos", ARQOS, 4'h7);
    check("single_arregion", ARREGION, 4'h1);
    check("single_aruser", ARUSER, 4'hC);
    check("single_berr", BURST_ERR, 0);
    step();
    check("single_drain_arvalid", ARVALID, 0);

    for (int i = 0; i < 16; i++) begin
      VALID = 1'b1; ARREADY = 1'b1;
      DATA  = mk(8'(i + 16), 2'b01);
      step();
      check($sformatf("tput%0d_arvalid", i), ARVALID, 1);
      check($sformatf("tput%0d_arid", i), ARID, 8'(i + 16));
      check($sformatf("tput%0d_ready", i), READY, 1);
    end
    VALID = 1'b0;
    step();
    check("tput_end_arvalid", ARVALID, 0);

    ARREADY = 1'b0; VALID = 1'b1;
    DATA = mk(8'h41, 2'b01);
    step();
    DATA = mk(8'h42, 2'b01);
    step();
    VALID = 1'b0;
    check("mid_full_ready", READY, 0);
    check("mid_full_arvalid", ARVALID, 1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_arvalid", ARVALID, 0);
    check("mid_rst_ready", READY, 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    ARREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mid_post%0d_arvalid", i), ARVALID, 0);
      check($sformatf("mid_post%0d_ready", i), READY, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r_forward_demixer.md
Name: r_forward_demixer

Overview:
Receive-side counterpart of the AR-channel forward mixer. It takes the 77-bit packed read-address word plus VALID/READY and unpacks it into a full AXI4 AR master-side channel. A 2-entry skid buffer registers both directions, so the packed link and the AR channel are timing-isolated at full throughput. It sits at the slave-facing end of the forward read-address path, after the crossbar or link.

Parameters:
None. The field layout is fixed by the shared package.

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active-high
DATA  in  77  packed AR word
VALID  in  1  DATA valid
READY  out  1  demixer can accept DATA (registered)
ARID  out  8  unpacked field
ARADDR  out  36  unpacked field
ARLEN  out  8  unpacked field
ARSIZE  out  3  unpacked field
ARBURST  out  2  unpacked field
ARLOCK  out  1  unpacked field
ARCACHE  out  4  unpacked field
ARPROT  out  3  unpacked field
ARQOS  out  4  unpacked field
ARREGION  out  4  unpacked field
ARUSER  out  4  unpacked field
ARVALID  out  1  AR channel valid (registered)
ARREADY  in  1  downstream accepts AR
BURST_ERR  out  1  one-cycle pulse: accepted word had ARBURST=2'b11 (reserved)

Behaviour:
- Field map, MSB to LSB:
  - ID[76:69], ADDR[68:33], LEN[32:25], SIZE[24:22], BURST[21:20], LOCK[19]
  - CACHE[18:15], PROT[14:12], QOS[11:8], REGION[7:4], USER[3:0]
- Input transfer: VALID && READY on a CLK rise. Output transfer: ARVALID && ARREADY on a CLK rise.
- Storage: output register OREG (drives all AR fields) and skid register SREG, each 77 bits.
- State machine:
  - EMPTY: ARVALID=0, READY=1. Input transfer loads OREG, go to ONE.
  - ONE: ARVALID=1, READY=1.
    - Input and output transfer together: OREG<=DATA, stay ONE.
    - Input transfer only: SREG<=DATA, go to FULL.
    - Output transfer only: go to EMPTY.
    - Neither: hold.
  - FULL: ARVALID=1, READY=0. Output transfer: OREG<=SREG, go to ONE. Otherwise hold.
- READY is a flop equal to (next state != FULL). It never depends combinationally on ARREADY.
- Latency: 1 cycle from input transfer to ARVALID. Throughput: 1 word/cycle while ARREADY is held 1.
- AXI rules:
  - While ARVALID=1 and ARREADY=0, all AR fields stay stable.
  - ARVALID never drops without an output transfer.
- Ordering: strict FIFO. A word in SREG is always presented before any later word.
- BURST_ERR: registered. It is 1 in the cycle after an input transfer whose DATA[21:20]=2'b11. The word is still forwarded unchanged; checking is not the demixer's job.
- Reset (async assert, sync release):
  - State is EMPTY. ARVALID=0, READY=0, BURST_ERR=0, OREG and SREG all zero.
  - READY goes to 1 on the first CLK rise after RESET deasserts.
  - RESET mid-operation discards buffered words; no partial output follows.
- VALID while READY=0 is ignored, and DATA is not sampled.

Decomposition:
- Shared package holds:
  - Field width constants (AR_ID_W=8, AR_ADDR_W=36, …) and AR_PACK_W=77.
  - Bit-offset constants for each field.
  - BURST_RESERVED=2'b11.
  - State encoding: EMPTY/ONE/FULL.
- The same package is used by the mixer so pack and unpack cannot drift.
- One sub-module is natural: axi_skid_buffer, a generic width-parameterised 2-entry register slice. The demixer instantiates it with width AR_PACK_W, then adds the field slicing and BURST_ERR logic.

Test Plan:
- Reset release: READY=0 during RESET, 1 one cycle after release. ARVALID=0 and all AR fields=0 throughout reset.
- Single word, ARREADY=1:
  - Stimulus: DATA={8'hA5, 36'h9_1234_5678, 8'h0F, 3'd3, 2'b01, 1'b0, 4'h3, 3'd2, 4'h7, 4'h1, 4'hC}.
  - Response: next cycle ARID=8'hA5, ARADDR=36'h912345678, ARLEN=8'h0F, ARSIZE=3, ARBURST=01, ARUSER=4'hC, ARVALID=1. BURST_ERR stays 0.
- Backpressure: stream IDs 1..4 with ARREADY=0.
  - READY drops after the 2nd accepted word; ID1 held stable on AR outputs.
  - Raise ARREADY: IDs emerge 1,2,3,4 in order with no loss or duplication.
- Full throughput: 16 back-to-back words, ARREADY=1 → ARVALID continuously 1 for 16 cycles, one cycle after the first input.
- Reserved burst: word with DATA[21:20]=2'b11 → BURST_ERR=1 for exactly one cycle; ARBURST=2'b11 is still forwarded.
- Mid-operation reset: FULL state (2 words held), assert RESET → ARVALID=0 immediately; after release, no stale word appears.
